// File: rtl/uart_pkg.sv
// uart_pkg: shared data width and FSM state encoding for the UART transmit queue
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    LOAD      = ST_LOAD,
    WAIT_DONE = ST_WAIT_DONE
  } state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: byte FIFO with count-based full/empty, sticky overflow and synchronous clear
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_wr_en, i_wr_data      push request and byte
//   i_clear                 flush contents and overflow; same-cycle push ignored
//   i_pop                   pop strobe; o_rd_data shows the head byte
//   o_full, o_empty         decoded from o_count
//   o_count, o_overflow     occupancy and sticky push-while-full flag
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [UART_DATA_W-1:0] i_wr_data,
  input  logic                   i_clear,
  input  logic                   i_pop,
  output logic [UART_DATA_W-1:0] o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [AW:0]            o_count,
  output logic                   o_overflow
);
  logic [UART_DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   w_push;
  logic                   w_pop;
  assign o_full    = r_count == (AW+1)'(DEPTH);
  assign o_empty   = r_count == '0;
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  // fullness is judged before any same-cycle pop, so a push into a full FIFO is always dropped
  assign w_push = i_wr_en & ~o_full & ~i_clear;
  assign w_pop  = i_pop & ~o_empty;
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (i_wr_en && o_full) o_overflow <= 1'b1;
    end
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue feeding a UART core's transmit handshake, paced by uart_tx_busy
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_wr_en, i_wr_data      push a byte from host logic
//   i_clear                 flush queued bytes and overflow; a latched frame still completes
//   o_full, o_empty         queue occupancy decode
//   o_count, o_overflow     bytes stored, sticky push-while-full
//   i_uart_tx_busy          UART core is shifting a frame
//   o_init_tx               transmit request, held until the UART shows busy
//   o_uart_data_in          byte presented to the UART, stable while o_init_tx=1
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [UART_DATA_W-1:0] i_wr_data,
  input  logic                   i_clear,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [AW:0]            o_count,
  output logic                   o_overflow,
  input  logic                   i_uart_tx_busy,
  output logic                   o_init_tx,
  output logic [UART_DATA_W-1:0] o_uart_data_in
);
  state_t                 r_state;
  logic                   w_pop;
  logic [UART_DATA_W-1:0] w_rd_data;
  assign w_pop = (r_state == IDLE) & ~o_empty & ~i_uart_tx_busy;
  sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .i_clear    (i_clear),
    .i_pop      (w_pop),
    .o_rd_data  (w_rd_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );
  // LOAD holds init_tx until busy is seen, since the UART may refuse a load while receiving
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state        <= IDLE;
      o_init_tx      <= 1'b0;
      o_uart_data_in <= '0;
    end else
      case (r_state)
        IDLE:
          if (w_pop) begin
            o_uart_data_in <= w_rd_data;
            o_init_tx      <= 1'b1;
            r_state        <= LOAD;
          end
        LOAD:
          if (i_uart_tx_busy) begin
            o_init_tx <= 1'b0;
            r_state   <= WAIT_DONE;
          end
        WAIT_DONE:
          if (!i_uart_tx_busy) r_state <= IDLE;
        default: begin
          o_init_tx <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: scoreboard bench for uart_tx_queue with a behavioural UART busy model
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clear;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          busy;
  logic          init_tx;
  logic [7:0]    data_out;
  logic          m_busy;
  logic          hold;
  bit            refuse;
  int            busy_len;
  logic [7:0]    exp_q[$];
  logic          exp_ovf;
  int            n_tests;
  int            n_fail;
  assign busy = m_busy | hold;
  always #10 clk = ~clk;
  uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_wr_en        (wr_en),
    .i_wr_data      (wr_data),
    .i_clear        (clear),
    .o_full         (full),
    .o_empty        (empty),
    .o_count        (count),
    .o_overflow     (overflow),
    .i_uart_tx_busy (busy),
    .o_init_tx      (init_tx),
    .o_uart_data_in (data_out)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic push(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovf = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic wait_drain(input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || busy || init_tx) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("drain_done", 32'(i < budget), 1);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    m_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && init_tx === 1'b1 && !busy && !refuse) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("uart_byte", data_out, exp_q.pop_front());
        @(negedge clk);
        m_busy = 1'b1;
        @(negedge clk);
        chk("init_drop", init_tx, 0);
        repeat (busy_len - 1) @(negedge clk);
        m_busy = 1'b0;
      end
    end
  end
  initial begin
    int k;
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b1;
    wr_data  = 8'h5A;
    clear    = 1'b0;
    hold     = 1'b0;
    refuse   = 1'b0;
    busy_len = 11 * 434;
    exp_ovf  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_init", init_tx, 0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_ovf", overflow, 0);
    wr_en = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_count", count, 0);
    push(8'hA5);
    chk("lat_empty", empty, 0);
    chk("lat_count", count, 1);
    chk("lat_init0", init_tx, 0);
    @(negedge clk);
    chk("lat_init1", init_tx, 1);
    chk("lat_data", data_out, 8'hA5);
    wait_drain(6000);
    chk("single_count", count, 0);
    chk("single_init", init_tx, 0);
    busy_len = 20;
    hold = 1'b1;
    for (int i = 0; i < 20; i++) push(8'(i));
    chk("order_count", count, DEPTH);
    chk("order_full", full, 1);
    chk("order_ovf", overflow, exp_ovf);
    chk("order_ovf_set", overflow, 1);
    @(negedge clk);
    hold = 1'b0;
    wait_drain(2000);
    chk("order_empty", empty, 1);
    chk("order_ovf_sticky", overflow, 1);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'hB0 + i));
    @(negedge clk);
    hold = 1'b0;
    k = 0;
    while (!m_busy && k < 100) begin
      @(posedge clk);
      k++;
    end
    k = 0;
    while (m_busy && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk("sim_wait", 32'(k < 100), 1);
    #1;
    chk("sim_count_before", count, 3);
    wr_en   = 1'b1;
    wr_data = 8'hB4;
    exp_q.push_back(8'hB4);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("sim_count", count, 3);
    chk("sim_init", init_tx, 1);
    wait_drain(1000);
    refuse = 1'b1;
    push(8'hC3);
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      chk("refuse_init", init_tx, 1);
      chk("refuse_data", data_out, 8'hC3);
      @(negedge clk);
    end
    hold = 1'b1;
    @(negedge clk);
    chk("refuse_drop", init_tx, 0);
    chk("refuse_byte", data_out, exp_q.pop_front());
    hold   = 1'b0;
    refuse = 1'b0;
    repeat (3) @(negedge clk);
    chk("refuse_idle", init_tx, 0);
    busy_len = 200;
    for (int i = 0; i < 6; i++) push(8'(8'hD0 + i));
    chk("clr_count_before", count, 5);
    chk("clr_ovf_before", overflow, exp_ovf);
    chk("clr_busy", busy, 1);
    @(negedge clk);
    clear   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    @(negedge clk);
    clear = 1'b0;
    wr_en = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_empty", empty, 1);
    chk("clr_ovf", overflow, exp_ovf);
    chk("clr_init", init_tx, 0);
    wait_drain(1000);
    chk("clr_after_count", count, 0);
    chk("clr_after_init", init_tx, 0);
    busy_len = 20;
    refuse = 1'b1;
    push(8'hE7);
    k = 0;
    while (!init_tx && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("arst_load", init_tx, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_init", init_tx, 0);
    chk("arst_data", data_out, 8'h00);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    refuse = 1'b0;
    push(8'h3C);
    wait_drain(1000);
    chk("final_count", count, 0);
    chk("final_ovf", overflow, exp_ovf);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
